// File: rtl/input_cond_pkg.sv
// Shared constants for the pushbutton/switch input conditioner.
// Debounce lengths cover both the real board and short simulation runs.
package input_cond_pkg;

   localparam int DEBOUNCE_10MS = 500000;
   localparam int DEBOUNCE_SIM  = 4;

   localparam int NUM_KEYS_DEF  = 2;
   localparam int NUM_SW_DEF    = 8;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a hold-time debouncer.
// Output 0 always means "idle" (key released / switch at its reset value).
module debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic SYNC_RESET_VAL  = 1'b0,
   parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic Clk,
   input  logic Reset,
   input  logic din,
   output logic dout,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sample;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q  <= SYNC_RESET_VAL;
         sync2_q  <= SYNC_RESET_VAL;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= din;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // Idle level maps to 0, so active-low keys come out as 1 = pressed.
   assign sample = sync2_q ^ SYNC_RESET_VAL;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      rise     = 1'b0;
      if (sample != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sample;
            rise     = sample;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign dout = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces board keys and switches; keys also get a
// one-cycle press pulse and a sticky pending flag cleared by key_ack.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int NUM_KEYS        = NUM_KEYS_DEF,
   parameter int NUM_SW          = NUM_SW_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [NUM_KEYS-1:0] key_n,
   input  logic [NUM_SW-1:0]   sw_raw,
   input  logic [NUM_KEYS-1:0] key_ack,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_pending,
   output logic [NUM_SW-1:0]   sw_level
);

   logic [NUM_KEYS-1:0] key_rise;
   logic [NUM_SW-1:0]   sw_rise;
   logic [NUM_KEYS-1:0] key_press_q, key_press_d;
   logic [NUM_KEYS-1:0] key_pend_q, key_pend_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_RESET_VAL  (1'b1),
            .CNT_W           (CNT_W)
         ) u_db (
            .Clk   (Clk),
            .Reset (Reset),
            .din   (key_n[gi]),
            .dout  (key_level[gi]),
            .rise  (key_rise[gi])
         );
      end
      for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
         debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_RESET_VAL  (1'b0),
            .CNT_W           (CNT_W)
         ) u_db (
            .Clk   (Clk),
            .Reset (Reset),
            .din   (sw_raw[gi]),
            .dout  (sw_level[gi]),
            .rise  (sw_rise[gi])
         );
      end
   endgenerate

   // Set beats acknowledge when both land on the same edge.
   always_comb begin
      key_press_d = key_rise;
      key_pend_d  = key_rise | (key_pend_q & ~key_ack);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         key_press_q <= '0;
         key_pend_q  <= '0;
      end else begin
         key_press_q <= key_press_d;
         key_pend_q  <= key_pend_d;
      end
   end

   assign key_press   = key_press_q;
   assign key_pending = key_pend_q;

   logic unused_sw_rise;
   assign unused_sw_rise = ^sw_rise;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed test of input_conditioner with a 4-cycle debounce.
// Edge 0 is the first rising edge sampling a new raw value.
module tb_input_conditioner;

   logic       Clk;
   logic       Reset;
   logic [1:0] key_n;
   logic [7:0] sw_raw;
   logic [1:0] key_ack;
   logic [1:0] key_level;
   logic [1:0] key_press;
   logic [1:0] key_pending;
   logic [7:0] sw_level;

   int passed;
   int total;

   input_conditioner #(
      .NUM_KEYS        (2),
      .NUM_SW          (8),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .key_n       (key_n),
      .sw_raw      (sw_raw),
      .key_ack     (key_ack),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_pending (key_pending),
      .sw_level    (sw_level)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset   = 1'b1;
      key_n   = 2'b11;
      sw_raw  = 8'h00;
      key_ack = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({key_level, key_press, key_pending, sw_level} !== 14'h0)
            $display("FAIL reset_hold[%0d]: got %h want 0", i,
                     {key_level, key_press, key_pending, sw_level});
         else passed++;
      end
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({key_level, key_press, key_pending, sw_level} !== 14'h0)
            $display("FAIL reset_after[%0d]: got %h want 0", i,
                     {key_level, key_press, key_pending, sw_level});
         else passed++;
      end
   endtask

   task automatic test_clean_press();
      key_n[0] = 1'b0;
      for (int e = 0; e < 5; e++) begin
         tick();
         total++;
         if (key_level !== 2'b00 || key_press !== 2'b00)
            $display("FAIL press_early[%0d]: got lvl=%b prs=%b want 00/00",
                     e, key_level, key_press);
         else passed++;
      end
      tick();
      total++;
      if (key_level !== 2'b01 || key_press !== 2'b01 || key_pending !== 2'b01)
         $display("FAIL press_edge5: got %b/%b/%b want 01/01/01",
                  key_level, key_press, key_pending);
      else passed++;
      tick();
      total++;
      if (key_press !== 2'b00 || key_pending !== 2'b01 || key_level !== 2'b01)
         $display("FAIL press_edge6: got prs=%b pnd=%b lvl=%b want 00/01/01",
                  key_press, key_pending, key_level);
      else passed++;
      key_n[0] = 1'b1;
      for (int e = 0; e < 7; e++) begin
         tick();
         total++;
         if (key_press !== 2'b00)
            $display("FAIL release_pulse[%0d]: got %b want 00", e, key_press);
         else passed++;
      end
      total++;
      if (key_level !== 2'b00 || key_pending !== 2'b01)
         $display("FAIL release_level: got lvl=%b pnd=%b want 00/01",
                  key_level, key_pending);
      else passed++;
      key_ack = 2'b01;
      tick();
      key_ack = 2'b00;
      total++;
      if (key_pending !== 2'b00)
         $display("FAIL ack_clear: got %b want 00", key_pending);
      else passed++;
   endtask

   task automatic test_bounce();
      key_n[1] = 1'b0;
      for (int e = 0; e < 3; e++) begin
         tick();
         total++;
         if (key_level !== 2'b00 || key_press !== 2'b00)
            $display("FAIL bounce_burst[%0d]: got lvl=%b prs=%b want 00/00",
                     e, key_level, key_press);
         else passed++;
      end
      key_n[1] = 1'b1;
      tick();
      key_n[1] = 1'b0;
      for (int e = 0; e < 5; e++) begin
         tick();
         total++;
         if (key_level !== 2'b00 || key_press !== 2'b00)
            $display("FAIL bounce_wait[%0d]: got lvl=%b prs=%b want 00/00",
                     e, key_level, key_press);
         else passed++;
      end
      tick();
      total++;
      if (key_press !== 2'b10 || key_level !== 2'b10 || key_pending !== 2'b10)
         $display("FAIL bounce_fire: got %b/%b/%b want 10/10/10",
                  key_press, key_level, key_pending);
      else passed++;
      key_n[1] = 1'b1;
      for (int e = 0; e < 7; e++) tick();
      key_ack = 2'b10;
      tick();
      key_ack = 2'b00;
      total++;
      if (key_pending !== 2'b00 || key_level !== 2'b00)
         $display("FAIL bounce_cleanup: got pnd=%b lvl=%b want 00/00",
                  key_pending, key_level);
      else passed++;
   endtask

   task automatic test_ack_collision();
      key_n[0] = 1'b0;
      for (int e = 0; e < 5; e++) tick();
      key_ack = 2'b01;
      tick();
      key_ack = 2'b00;
      total++;
      if (key_pending !== 2'b01 || key_press !== 2'b01)
         $display("FAIL collide_set: got pnd=%b prs=%b want 01/01",
                  key_pending, key_press);
      else passed++;
      tick();
      total++;
      if (key_pending !== 2'b01)
         $display("FAIL collide_hold: got %b want 01", key_pending);
      else passed++;
      key_ack = 2'b01;
      tick();
      key_ack = 2'b00;
      total++;
      if (key_pending !== 2'b00)
         $display("FAIL collide_ack: got %b want 00", key_pending);
      else passed++;
      key_ack = 2'b01;
      tick();
      key_ack = 2'b00;
      total++;
      if (key_pending !== 2'b00 || key_press !== 2'b00)
         $display("FAIL ack_idle: got pnd=%b prs=%b want 00/00",
                  key_pending, key_press);
      else passed++;
      key_n[0] = 1'b1;
      for (int e = 0; e < 7; e++) tick();
      total++;
      if (key_level !== 2'b00 || key_pending !== 2'b00)
         $display("FAIL collide_cleanup: got lvl=%b pnd=%b want 00/00",
                  key_level, key_pending);
      else passed++;
   endtask

   task automatic test_switches();
      sw_raw = 8'hA5;
      for (int e = 0; e < 5; e++) begin
         tick();
         total++;
         if (sw_level !== 8'h00)
            $display("FAIL sw_early[%0d]: got %h want 00", e, sw_level);
         else passed++;
      end
      tick();
      total++;
      if (sw_level !== 8'hA5)
         $display("FAIL sw_accept: got %h want a5", sw_level);
      else passed++;
      sw_raw = 8'hFF;
      tick();
      sw_raw = 8'hA5;
      for (int e = 0; e < 8; e++) begin
         tick();
         total++;
         if (sw_level !== 8'hA5)
            $display("FAIL sw_glitch[%0d]: got %h want a5", e, sw_level);
         else passed++;
      end
      total++;
      if (key_press !== 2'b00 || key_pending !== 2'b00)
         $display("FAIL sw_no_key: got prs=%b pnd=%b want 00/00",
                  key_press, key_pending);
      else passed++;
   endtask

   task automatic test_reset_held();
      key_n[0] = 1'b0;
      for (int e = 0; e < 3; e++) begin
         tick();
         total++;
         if (key_press !== 2'b00)
            $display("FAIL rst_pre[%0d]: got %b want 00", e, key_press);
         else passed++;
      end
      Reset = 1'b1;
      tick();
      total++;
      if ({key_level, key_press, key_pending, sw_level} !== 14'h0)
         $display("FAIL rst_mid: got %h want 0",
                  {key_level, key_press, key_pending, sw_level});
      else passed++;
      tick();
      Reset = 1'b0;
      for (int e = 0; e < 5; e++) begin
         tick();
         total++;
         if (key_press !== 2'b00 || key_level !== 2'b00)
            $display("FAIL rst_post_wait[%0d]: got prs=%b lvl=%b want 00/00",
                     e, key_press, key_level);
         else passed++;
      end
      tick();
      total++;
      if (key_press !== 2'b01 || key_level !== 2'b01 || key_pending !== 2'b01)
         $display("FAIL rst_post_fire: got %b/%b/%b want 01/01/01",
                  key_press, key_level, key_pending);
      else passed++;
      total++;
      if (sw_level !== 8'hA5)
         $display("FAIL rst_post_sw: got %h want a5", sw_level);
      else passed++;
      tick();
      total++;
      if (key_press !== 2'b00)
         $display("FAIL rst_post_pulse: got %b want 00", key_press);
      else passed++;
   endtask

   initial begin
      passed  = 0;
      total   = 0;
      Reset   = 1'b1;
      key_n   = 2'b11;
      sw_raw  = 8'h00;
      key_ack = 2'b00;
      test_reset();
      test_clean_press();
      test_bounce();
      test_ack_collision();
      test_switches();
      test_reset_held();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
